// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 Set 2 scan-code decoder.
package ps2_pkg;

  localparam int unsigned CODE_W = 8;
  localparam int unsigned EVT_W  = CODE_W + 2;
  localparam int unsigned SKIP_W = 3;

  // Prefix and special bytes
  localparam logic [CODE_W-1:0] SC_EXT        = 8'hE0;
  localparam logic [CODE_W-1:0] SC_BRK        = 8'hF0;
  localparam logic [CODE_W-1:0] SC_PAUSE      = 8'hE1;
  localparam logic [CODE_W-1:0] SC_FAKE_SHIFT = 8'h12;

  // Keyboard error/overrun bytes
  localparam logic [CODE_W-1:0] SC_ERR_00 = 8'h00;
  localparam logic [CODE_W-1:0] SC_ERR_FF = 8'hFF;

  // Protocol responses that never form key events
  localparam logic [CODE_W-1:0] SC_BAT_OK   = 8'hAA;
  localparam logic [CODE_W-1:0] SC_ACK      = 8'hFA;
  localparam logic [CODE_W-1:0] SC_BAT_FAIL = 8'hFC;
  localparam logic [CODE_W-1:0] SC_DIAG_ERR = 8'hFD;
  localparam logic [CODE_W-1:0] SC_ECHO     = 8'hEE;

  // Bytes following E1 before the pause event is complete
  localparam logic [SKIP_W-1:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk,
    StPause
  } dec_state_e;

  typedef struct packed {
    logic              ext;
    logic              rel;
    logic [CODE_W-1:0] code;
  } ps2_evt_t;

  typedef struct packed {
    logic              valid;
    logic              ext;
    logic [CODE_W-1:0] code;
  } last_make_t;

endpackage

// File: rtl/ps2_scan_decoder_if.sv
// Byte-input / event-output bundle of the scan decoder.
interface ps2_scan_decoder_if #(
  parameter int unsigned FIFO_DEPTH = 8
);
  import ps2_pkg::*;

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [CODE_W-1:0] scan_code;
  logic              new_data;
  logic              evt_rd;
  logic              clr_status;
  logic [EVT_W-1:0]  evt_data;
  logic              evt_valid;
  logic              fifo_full;
  logic [PTR_W:0]    evt_count;
  logic              overflow;
  logic              err_code;

  // Receiver / CPU side
  modport master (
    output scan_code, new_data, evt_rd, clr_status,
    input  evt_data, evt_valid, fifo_full, evt_count, overflow, err_code
  );

  // Decoder side
  modport slave (
    input  scan_code, new_data, evt_rd, clr_status,
    output evt_data, evt_valid, fifo_full, evt_count, overflow, err_code
  );
endinterface

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO for key events. A write while full is accepted only when a read
// on the same cycle frees a slot.
module ps2_event_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             rd_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PtrW:0]    count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_wr, do_rd;

  // Accept/pop decisions and pointer/count next state
  always_comb begin
    do_rd    = rd_i && (count_q != '0);
    do_wr    = wr_i && ((count_q != Depth[PtrW:0]) || do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_wr && !do_rd) count_d = count_q + 1'b1;
    else if (!do_wr && do_rd) count_d = count_q - 1'b1;
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == Depth[PtrW:0]);
  assign count_o = count_q;
  // Hold zero while empty so the head output is clean out of reset
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 Set 2 scan-code decoder: folds E0/F0/E1 sequences into key events and queues them.
// Optional build macro TYPEMATIC_FILTER_EN suppresses repeated makes of the held key.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH)
) (
  input logic           clk,
  input logic           reset,
  ps2_scan_decoder_if.slave bus
);

  dec_state_e        state_q, state_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic              overflow_q, overflow_d;
  logic              err_code_q, err_code_d;
  logic              emit, err_set, fifo_wr;
  ps2_evt_t          evt;
  logic [EVT_W-1:0]  fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [PTR_W:0]    fifo_count;
  logic [CODE_W-1:0] b;

  assign b = bus.scan_code;

  // Decoder next state and event generation, only on received bytes
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    emit    = 1'b0;
    err_set = 1'b0;
    evt     = '0;
    if (bus.new_data) begin
      unique case (state_q)
        StIdle: begin
          case (b)
            SC_EXT:   state_d = StExt;
            SC_BRK:   state_d = StBrk;
            SC_PAUSE: begin
              state_d = StPause;
              skip_d  = PAUSE_SKIP;
            end
            SC_ERR_00, SC_ERR_FF: err_set = 1'b1;
            SC_BAT_OK, SC_ACK, SC_BAT_FAIL, SC_DIAG_ERR, SC_ECHO: ;
            default: begin
              emit = 1'b1;
              evt  = '{ext: 1'b0, rel: 1'b0, code: b};
            end
          endcase
        end
        StExt: begin
          if (b == SC_BRK) begin
            state_d = StExtBrk;
          end else if (b == SC_EXT) begin
            state_d = StExt;
          end else begin
            state_d = StIdle;
            if (b != SC_FAKE_SHIFT) begin
              emit = 1'b1;
              evt  = '{ext: 1'b1, rel: 1'b0, code: b};
            end
          end
        end
        StBrk: begin
          state_d = StIdle;
          emit    = 1'b1;
          evt     = '{ext: 1'b0, rel: 1'b1, code: b};
        end
        StExtBrk: begin
          state_d = StIdle;
          if (b != SC_FAKE_SHIFT) begin
            emit = 1'b1;
            evt  = '{ext: 1'b1, rel: 1'b1, code: b};
          end
        end
        StPause: begin
          skip_d = skip_q - 1'b1;
          if (skip_q == 3'd1) begin
            state_d = StIdle;
            emit    = 1'b1;
            evt     = '{ext: 1'b1, rel: 1'b0, code: SC_PAUSE};
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Decoder state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

`ifdef TYPEMATIC_FILTER_EN
  last_make_t last_make_q, last_make_d;
  logic       same_key;

  // Drop repeats of the held key; its break re-arms the filter
  always_comb begin
    last_make_d = last_make_q;
    fifo_wr     = emit;
    same_key    = last_make_q.valid && (last_make_q.ext == evt.ext) &&
                  (last_make_q.code == evt.code);
    if (emit) begin
      if (!evt.rel) begin
        if (same_key) fifo_wr = 1'b0;
        else last_make_d = '{valid: 1'b1, ext: evt.ext, code: evt.code};
      end else if (same_key) begin
        last_make_d.valid = 1'b0;
      end
    end
  end

  // Last emitted make
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_make_q <= '0;
    else       last_make_q <= last_make_d;
  end
`else
  assign fifo_wr = emit;
`endif

  // Set-dominant sticky status flags
  always_comb begin
    overflow_d = (overflow_q && !bus.clr_status) ||
                 (fifo_wr && fifo_full && !bus.evt_rd);
    err_code_d = (err_code_q && !bus.clr_status) || err_set;
  end

  // Status flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
      err_code_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      err_code_q <= err_code_d;
    end
  end

  ps2_event_fifo #(
    .Width (EVT_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .wr_i    (fifo_wr),
    .wdata_i (evt),
    .rd_i    (bus.evt_rd),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus.evt_data  = fifo_rdata;
  assign bus.evt_valid = !fifo_empty;
  assign bus.fifo_full = fifo_full;
  assign bus.evt_count = fifo_count;
  assign bus.overflow  = overflow_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench for ps2_scan_decoder: expected events are queued as bytes are sent and
// a negedge monitor checks every popped head entry against the queue.
module tb_ps2_scan_decoder;

  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [9:0] exp_q [$];

  ps2_scan_decoder_if #(.FIFO_DEPTH(DEPTH)) bus ();

  ps2_scan_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: whatever head is popped must match the oldest expected event
  always @(negedge clk) begin
    if (!reset && bus.evt_rd && bus.evt_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pop: got 0x%0h expected no entry", bus.evt_data);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if (bus.evt_data !== e) begin
          failures++;
          $display("FAIL evt_pop: got 0x%0h expected 0x%0h", bus.evt_data, e);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit rd = 1'b0, input bit clr = 1'b0);
    @(posedge clk); #1;
    bus.scan_code  = b;
    bus.new_data   = 1'b1;
    bus.evt_rd     = rd;
    bus.clr_status = clr;
    @(posedge clk); #1;
    bus.new_data   = 1'b0;
    bus.evt_rd     = 1'b0;
    bus.clr_status = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    bus.clr_status = 1'b1;
    @(posedge clk); #1;
    bus.clr_status = 1'b0;
  endtask

  // Pop up to n entries, then confirm nothing expected or stored is left over
  task automatic drain(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.evt_rd = 1'b1;
    end
    @(posedge clk); #1;
    bus.evt_rd = 1'b0;
    check({tag, "_leftover_expected"}, exp_q.size(), 0);
    check({tag, "_evt_valid_after_drain"}, int'(bus.evt_valid), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    #12;
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    bus.scan_code  = '0;
    bus.new_data   = 1'b0;
    bus.evt_rd     = 1'b0;
    bus.clr_status = 1'b0;
    #23 reset = 1'b0;
    @(posedge clk); #1;

    // Reset state
    check("rst_evt_valid", int'(bus.evt_valid), 0);
    check("rst_evt_count", int'(bus.evt_count), 0);
    check("rst_fifo_full", int'(bus.fifo_full), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    check("rst_err_code", int'(bus.err_code), 0);
    check("rst_evt_data", int'(bus.evt_data), 0);

    // 1: make and break of A
    exp_q.push_back(10'h01C); send(8'h1C);
    send(8'hF0);
    exp_q.push_back(10'h11C); send(8'h1C);
    check("t1_count", int'(bus.evt_count), 2);
    check("t1_valid", int'(bus.evt_valid), 1);
    drain(4, "t1");

    // 2: extended make/break, fake shift dropped
    send(8'hE0); exp_q.push_back(10'h275); send(8'h75);
    send(8'hE0); send(8'hF0); exp_q.push_back(10'h375); send(8'h75);
    send(8'hE0); send(8'h12);
    check("t2_count", int'(bus.evt_count), 2);
    drain(4, "t2");

    // 3: pause sequence yields one event, then decoder is back in IDLE
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1); send(8'hF0); send(8'h14);
    send(8'hF0);
    check("t3_count_before_last", int'(bus.evt_count), 0);
    exp_q.push_back(10'h2E1); send(8'h77);
    check("t3_count", int'(bus.evt_count), 1);
    exp_q.push_back(10'h01C); send(8'h1C);
    check("t3_idle_count", int'(bus.evt_count), 2);
    drain(4, "t3");

    // 4: fill, overflow, clear, simultaneous write+read while full
    for (int i = 0; i < 8; i++) begin
      logic [7:0] c;
      c = 8'h15 + 8'(i);
      exp_q.push_back({2'b00, c});
      send(c);
    end
    check("t4_full_at_8", int'(bus.fifo_full), 1);
    check("t4_no_ovf_at_8", int'(bus.overflow), 0);
    send(8'h1D);
    check("t4_full", int'(bus.fifo_full), 1);
    check("t4_overflow", int'(bus.overflow), 1);
    check("t4_head", int'(bus.evt_data), 'h015);
    check("t4_count_full", int'(bus.evt_count), 8);
    pulse_clr();
    check("t4_ovf_cleared", int'(bus.overflow), 0);
    exp_q.push_back(10'h01E); send(8'h1E, 1'b1);
    check("t4_head_after_rw", int'(bus.evt_data), 'h016);
    check("t4_count_after_rw", int'(bus.evt_count), 8);
    check("t4_no_ovf_rw", int'(bus.overflow), 0);
    drain(10, "t4");

    // 5: error byte sticky, discard byte, set beats clear, reset mid-sequence
    send(8'hFF);
    send(8'hAA);
    check("t5_err_code", int'(bus.err_code), 1);
    check("t5_no_entries", int'(bus.evt_count), 0);
    send(8'h00, 1'b0, 1'b1);
    check("t5_err_set_dominant", int'(bus.err_code), 1);
    pulse_clr();
    check("t5_err_cleared", int'(bus.err_code), 0);
    send(8'hFA); send(8'hFC); send(8'hFD); send(8'hEE);
    check("t5_discards", int'(bus.evt_count), 0);
    send(8'hE0);
    do_reset();
    check("t5_rst_count", int'(bus.evt_count), 0);
    exp_q.push_back(10'h01C); send(8'h1C);
    check("t5_after_rst_head", int'(bus.evt_data), 'h01C);
    drain(3, "t5");

    // 6: typematic repeats
    exp_q.push_back(10'h01C); send(8'h1C);
`ifdef TYPEMATIC_FILTER_EN
    send(8'h1C); send(8'h1C);
`else
    exp_q.push_back(10'h01C); send(8'h1C);
    exp_q.push_back(10'h01C); send(8'h1C);
`endif
    send(8'hF0); exp_q.push_back(10'h11C); send(8'h1C);
    exp_q.push_back(10'h01C); send(8'h1C);
`ifdef TYPEMATIC_FILTER_EN
    check("t6_count", int'(bus.evt_count), 3);
`else
    check("t6_count", int'(bus.evt_count), 5);
`endif
    drain(7, "t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
Consumes the byte stream from the PS/2 receiver: the 8-bit scan_code plus a one-cycle new_data strobe, Set 2 codes.
Reassembles multi-byte sequences (E0 extended, F0 break, E1 pause) into single key events.
Pushes each event into a small FIFO that the CPU-side I/O logic pops via a read strobe.
Sits between ps2_keyboard and the memory-mapped keyboard register.

Parameters:
FIFO_DEPTH, 8, number of event entries; power of two, 2..64.
PTR_W, $clog2(FIFO_DEPTH), pointer width; derived, do not override.

Ports:
clk  in  1  system clock, same domain as ps2_keyboard.
reset  in  1  asynchronous, active-high reset.
scan_code  in  8  byte from receiver; valid only while new_data=1.
new_data  in  1  one-cycle strobe, one per received byte.
evt_rd  in  1  pop strobe; ignored when evt_valid=0.
clr_status  in  1  clears the overflow and err_code sticky flags.
evt_data  out  10  head entry {extended, release, code[7:0]}; combinational from the FIFO head.
evt_valid  out  1  FIFO not empty.
fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
evt_count  out  PTR_W+1  number of entries held.
overflow  out  1  sticky: an event was dropped because the FIFO was full.
err_code  out  1  sticky: a keyboard error/overrun byte (00 or FF) was received.

Behaviour:
- Reset values: all outputs 0; decoder state IDLE; FIFO empty; skip counter 0.
- The decoder acts only on cycles with new_data=1. On all other cycles its state holds.
- Decoder states and transitions (input byte b):
  - IDLE:
    - b=E0 -> EXT.
    - b=F0 -> BRK.
    - b=E1 -> PAUSE, skip counter=7.
    - b in {00, FF} -> set err_code, stay in IDLE.
    - b in {AA, FA, FC, FD, EE} -> discard, stay in IDLE.
    - any other b -> emit {0,0,b}, stay in IDLE.
  - EXT:
    - b=F0 -> EXT_BRK.
    - b=E0 -> stay in EXT.
    - b=12 (fake shift) -> IDLE, no event.
    - any other b -> emit {1,0,b}, go to IDLE.
  - BRK: any b -> emit {0,1,b}, go to IDLE.
  - EXT_BRK:
    - b=12 -> IDLE, no event.
    - any other b -> emit {1,1,b}, go to IDLE.
  - PAUSE: decrement the skip counter on each byte. When it reaches 0, emit {1,0,E1} and go to IDLE.
- Latency: an event is written on the new_data cycle of its final byte. evt_valid rises on the next clk edge.
- FIFO:
  - Write and read on the same cycle while not empty: both happen and evt_count is unchanged. This includes the full case; the write is accepted because the read frees a slot.
  - Write while full with no read: drop the event and set overflow. The FIFO contents are unchanged.
  - Read while empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH. evt_count saturates at FIFO_DEPTH by construction.
- Sticky flags: overflow and err_code are set-dominant. If clr_status and a set condition occur on the same cycle, the flag stays 1.
- Asynchronous reset mid-sequence (e.g. after E0): the sequence is abandoned, the state returns to IDLE, and the FIFO is emptied.

Optional Feature:
TYPEMATIC_FILTER_EN
- Defined:
  - A last_make register {valid, extended, code} tracks the most recently emitted make.
  - A make event equal to last_make is suppressed (no FIFO write).
  - A break of that key clears last_make.valid.
  - Any other make replaces last_make.
  - Reset clears last_make.
- Undefined: every typematic repeat make is enqueued.

Decomposition:
- Package ps2_pkg holds:
  - Scan constants: SC_EXT=8'hE0, SC_BRK=8'hF0, SC_PAUSE=8'hE1, SC_FAKE_SHIFT=8'h12, plus the discard/error byte constants.
  - Decoder state enum: IDLE, EXT, BRK, EXT_BRK, PAUSE.
  - Event field widths.
- One sub-module: ps2_event_fifo, a parameterised synchronous FIFO with write/read/full/empty/count. The decoder FSM stays in the top module.

Test Plan:
1. Bytes 1C, F0, 1C -> two entries: 01C (make A), then 11C (release A). evt_count=2.
2. Bytes E0 75, E0 F0 75 -> entries 275, then 375. Bytes E0 12 produce no entry.
3. Pause sequence E1 14 77 E1 F0 14 F0 77 -> exactly one entry, 2E1. State returns to IDLE.
4. Fill 8 makes (15, 16, ...), then send a 9th -> fifo_full=1, overflow=1, and the head is still 015. Pulse clr_status -> overflow=0. Send a 10th make with evt_rd=1 on the same cycle -> head becomes 016, evt_count stays 8.
5. Byte FF, then AA -> err_code=1, no entries. Assert reset after a lone E0, then send 1C -> entry 01C with extended=0.
6. With TYPEMATIC_FILTER_EN: bytes 1C, 1C, 1C, F0 1C, 1C -> entries 01C, 11C, 01C. Without the macro: five entries.
